note_sequencer: RTL
===================

Name: note_sequencer

Overview:
- Fetches 16-bit note words from a pattern ROM and decodes each into pitch and rest/gate information.
- Hands the 5-bit duration of each note to the downstream duration_counter, then waits for that counter's done strobe before advancing.
- Sits directly upstream of duration_counter. Pitch and gate outputs feed the channel's tone generator.

Parameters:
- ADDR_W, 8, pattern ROM address width; addresses wrap modulo 2^ADDR_W.
- PITCH_W, 9, pitch field width; fixed by the note word format and must equal 9.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  tick strobe; the same signal drives duration_counter i_enable
- i_start  in  1  one-cycle pulse: begin playback at i_start_addr
- i_start_addr  in  ADDR_W  first note address
- i_stop  in  1  one-cycle pulse: abort playback
- o_rom_addr  out  ADDR_W  pattern ROM address
- i_rom_data  in  16  ROM word; registered, valid 1 cycle after address
- o_load  out  1  to duration_counter i_load
- o_duration  out  5  to duration_counter i_duration
- i_done  in  1  from duration_counter o_done
- o_counter_clr  out  1  one-cycle pulse to duration_counter i_rst
- o_pitch  out  PITCH_W  current note pitch index
- o_gate  out  1  high while a non-rest note plays
- o_busy  out  1  high in any state except IDLE
- o_end  out  1  one-cycle pulse when the end marker stops playback

Behaviour:
- Note word format:
  - [15] END
  - [14] REST
  - [13:5] pitch
  - [4:0] duration
  - For an END word, [ADDR_W-1:0] holds the loop target address.
- Reset (async, i_rst_n low): state IDLE. All outputs 0; o_rom_addr = 0.
- State IDLE:
  - On i_start: set o_rom_addr = i_start_addr and pulse o_counter_clr; go to FETCH.
- State FETCH: address is presented; go to WAIT_ROM.
- State WAIT_ROM: i_rom_data is valid this cycle; register it.
  - If END: handle the end marker (see Optional Feature).
  - Otherwise:
    - o_duration = [4:0]; o_pitch = [13:5]; o_gate = ~REST.
    - Go to LOAD.
- State LOAD:
  - Assert o_load. Stay until a cycle with i_enable = 1; that cycle is the one in which the counter accepts the load.
  - Then deassert o_load and go to PLAY.
- State PLAY:
  - Hold pitch and gate.
  - On i_done (combinational from the counter, coincident with an i_enable tick): go to FETCH and set o_rom_addr = o_rom_addr + 1 (wraps).
  - o_gate stays high through the i_done cycle and drops to 0 on the following cycle for the inter-note gap.
- Timing: a note with duration d occupies the load tick plus d+1 further enable ticks. The fetch gap is 2 clocks, so with sparse ticks the next load lands on the next tick.
- i_stop:
  - Takes effect from any state.
  - Next cycle: state IDLE; o_load, o_gate and o_busy go to 0; o_counter_clr pulses.
  - o_pitch and o_rom_addr hold their values.
- Simultaneous events:
  - i_stop and i_start in the same cycle: stop wins.
  - i_start while busy: restart at i_start_addr, pulse o_counter_clr, go to FETCH.
  - i_done outside PLAY is ignored.
- o_busy = (state != IDLE).
- An END word never reaches the duration counter.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined:
  - An END word sets o_rom_addr = word[ADDR_W-1:0], drops o_gate and goes to FETCH. Playback continues and o_end does not pulse.
  - If END words chain back to back with no playable note in between, the block spins through FETCH/WAIT_ROM, bounded only by i_stop.
- Undefined:
  - An END word goes to IDLE, pulses o_end for 1 cycle and drops o_gate.
  - o_rom_addr holds the END word's address.

Test Plan:
- Reset mid-PLAY (i_rst_n low 1 cycle, async) -> all outputs 0 immediately; state IDLE; o_rom_addr = 0.
- ROM[4] = {REST=0, pitch 0x0A5, dur 3}, ROM[5] = END, SEQ_LOOP_EN undefined; i_start with addr 4; i_enable every 4th clock -> o_load held until the first tick; o_gate=1, o_pitch=0x0A5 for load tick + 4 ticks; then o_end pulses once, o_busy=0, o_rom_addr=5.
- REST note (word 0x4000 | dur 0) -> o_gate=0 throughout; o_duration=0; i_done on the tick after the load tick; advance to the next address.
- SEQ_LOOP_EN defined; ROM[0..1] = notes, ROM[2] = END with target 0 -> continuous playback 0,1,0,1…; o_end never pulses.
- i_stop during PLAY -> next cycle IDLE, o_gate=0, o_counter_clr=1 for 1 cycle; a subsequent i_start with addr 0 plays ROM[0] correctly.
- ADDR_W=8, start at 0xFF with a non-END note -> next fetch address 0x00; i_start and i_stop in the same cycle -> stays IDLE.

Source files
------------

// File: rtl/note_sequencer.sv
// Pattern-ROM note sequencer feeding duration_counter and the tone generator.
// Build option: define SEQ_LOOP_EN to make END words jump to their loop target instead of stopping.
module note_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int PITCH_W = 9
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_start,
    input  logic [ADDR_W-1:0]  i_start_addr,
    input  logic               i_stop,
    output logic [ADDR_W-1:0]  o_rom_addr,
    input  logic [15:0]        i_rom_data,
    output logic               o_load,
    output logic [4:0]         o_duration,
    input  logic               i_done,
    output logic               o_counter_clr,
    output logic [PITCH_W-1:0] o_pitch,
    output logic               o_gate,
    output logic               o_busy,
    output logic               o_end,
    output logic [2:0]         o_dbg_state
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FETCH    = 3'd1;
    localparam logic [2:0] WAIT_ROM = 3'd2;
    localparam logic [2:0] LOAD     = 3'd3;
    localparam logic [2:0] PLAY     = 3'd4;

    logic [2:0]         state_q,    state_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [4:0]         duration_q, duration_d;
    logic [PITCH_W-1:0] pitch_q,    pitch_d;
    logic               gate_q,     gate_d;
    logic               clr_q,      clr_d;
    logic               end_q,      end_d;

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        duration_d = duration_q;
        pitch_d    = pitch_q;
        gate_d     = gate_q;
        clr_d      = 1'b0;
        end_d      = 1'b0;
        // Stop outranks start; start restarts from any state.
        if (i_stop) begin
            state_d = IDLE;
            gate_d  = 1'b0;
            clr_d   = 1'b1;
        end else if (i_start) begin
            state_d    = FETCH;
            rom_addr_d = i_start_addr;
            gate_d     = 1'b0;
            clr_d      = 1'b1;
        end else begin
            case (state_q)
                FETCH: state_d = WAIT_ROM;
                WAIT_ROM: begin
                    if (i_rom_data[15]) begin
                        gate_d = 1'b0;
`ifdef SEQ_LOOP_EN
                        rom_addr_d = i_rom_data[ADDR_W-1:0];
                        state_d    = FETCH;
`else
                        end_d   = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        duration_d = i_rom_data[4:0];
                        pitch_d    = i_rom_data[5 +: PITCH_W];
                        gate_d     = ~i_rom_data[14];
                        state_d    = LOAD;
                    end
                end
                LOAD: if (i_enable) state_d = PLAY;
                PLAY: begin
                    // Gate stays up through the done cycle, then drops for the gap.
                    if (i_done) begin
                        state_d    = FETCH;
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        gate_d     = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            duration_q <= '0;
            pitch_q    <= '0;
            gate_q     <= 1'b0;
            clr_q      <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            duration_q <= duration_d;
            pitch_q    <= pitch_d;
            gate_q     <= gate_d;
            clr_q      <= clr_d;
            end_q      <= end_d;
        end
    end

    assign o_rom_addr    = rom_addr_q;
    assign o_load        = (state_q == LOAD);
    assign o_duration    = duration_q;
    assign o_counter_clr = clr_q;
    assign o_pitch       = pitch_q;
    assign o_gate        = gate_q;
    assign o_busy        = (state_q != IDLE);
    assign o_end         = end_q;
    assign o_dbg_state   = state_q;

endmodule
